// File: rtl/serial_core_wrap.sv
// Serial front end for a parallel core: serial in -> core_din, core_dout -> serial out.
// Optional even-parity trailer bit on sdo when SERIAL_PARITY_EN is defined.
module serial_core_wrap #(
  parameter int WIDTH      = 32,
  parameter int WORDS      = 1,
  parameter int PHASE_BITS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sdi,
  input  logic                        de,
  input  logic                        ld,
  input  logic                        pa,
  input  logic                        qe,
  output logic                        sdo,
  output logic [PHASE_BITS-1:0]       po,
  output logic                        frame_busy,
  output logic                        ovf,
  output logic [WIDTH*WORDS-1:0]      core_din,
  output logic                        core_load,
  output logic                        core_pa,
  input  logic [WIDTH*WORDS-1:0]      core_dout,
  input  logic [PHASE_BITS-1:0]       core_phase
);

  localparam int N = WIDTH * WORDS;
`ifdef SERIAL_PARITY_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif
  localparam int CW = $clog2(FL + 1);

  logic [N-1:0]  sr_in;
  logic [FL-1:0] sr_out;
  logic [CW-1:0] cnt;

  function automatic logic even_parity(input logic [N-1:0] word);
    return ^word;
  endfunction

  // Input side: free-running deserializer, snapshot into core controls on de
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_in     <= '0;
      core_din  <= '0;
      core_load <= 1'b0;
      core_pa   <= 1'b0;
    end else begin
      sr_in <= {sr_in[N-2:0], sdi};
      if (de) begin
        core_din  <= sr_in;
        core_load <= ld;
        core_pa   <= pa;
      end
    end
  end

  // Output side: qe restarts the frame (flagging overrun if more than the last bit was pending)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_out     <= '0;
      cnt        <= '0;
      po         <= '0;
      sdo        <= 1'b0;
      frame_busy <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      sdo <= sr_out[FL-1];
      if (qe) begin
`ifdef SERIAL_PARITY_EN
        sr_out <= {core_dout, even_parity(core_dout)};
`else
        sr_out <= core_dout;
`endif
        po         <= core_phase;
        cnt        <= CW'(FL);
        frame_busy <= 1'b1;
        if ({1'b0, cnt} >= (CW+1)'(2)) begin
          ovf <= 1'b1;
        end
      end else begin
        sr_out <= sr_out << 1;
        if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end
        // busy tracks the post-edge counter being nonzero
        frame_busy <= ({1'b0, cnt} > (CW+1)'(1));
      end
    end
  end

endmodule

// File: tb/tb_serial_core_wrap.sv
// Directed bench for serial_core_wrap: a 32x1 and a 16x2 instance driven with identical stimulus.
module tb_serial_core_wrap;

`ifdef SERIAL_PARITY_EN
  localparam int FL = 33;
`else
  localparam int FL = 32;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdi = 1'b0;
  logic        de  = 1'b0;
  logic        ld  = 1'b0;
  logic        pa  = 1'b0;
  logic        qe  = 1'b0;
  logic [31:0] core_dout  = 32'h0;
  logic [1:0]  core_phase = 2'd0;

  logic        a_sdo, a_busy, a_ovf, a_load, a_pa;
  logic [1:0]  a_po;
  logic [31:0] a_din;
  logic        b_sdo, b_busy, b_ovf, b_load, b_pa;
  logic [1:0]  b_po;
  logic [31:0] b_din;

  int checks   = 0;
  int failures = 0;

  serial_core_wrap #(.WIDTH(32), .WORDS(1), .PHASE_BITS(2)) dut_a (
    .clk(clk), .rst(rst), .sdi(sdi), .de(de), .ld(ld), .pa(pa), .qe(qe),
    .sdo(a_sdo), .po(a_po), .frame_busy(a_busy), .ovf(a_ovf),
    .core_din(a_din), .core_load(a_load), .core_pa(a_pa),
    .core_dout(core_dout), .core_phase(core_phase)
  );

  serial_core_wrap #(.WIDTH(16), .WORDS(2), .PHASE_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .sdi(sdi), .de(de), .ld(ld), .pa(pa), .qe(qe),
    .sdo(b_sdo), .po(b_po), .frame_busy(b_busy), .ovf(b_ovf),
    .core_din(b_din), .core_load(b_load), .core_pa(b_pa),
    .core_dout(core_dout), .core_phase(core_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) begin
      sdi = w[i];
      step();
    end
    sdi = 1'b0;
  endtask

  // Pulse qe with the given word and check the whole serial frame on both instances
  task automatic play(input logic [31:0] dout, input logic [1:0] ph, input logic exp_ovf);
    logic [33:0] stream;
    logic        par;
    int          busy_a;
    int          busy_b;
`ifdef SERIAL_PARITY_EN
    par = ^dout;
`else
    par = 1'b0;
`endif
    stream     = {dout, par, 1'b0};
    core_dout  = dout;
    core_phase = ph;
    qe = 1'b1;
    step();
    qe = 1'b0;
    de = 1'b0;
    chk("po_a", 64'(a_po), 64'(ph));
    chk("po_b", 64'(b_po), 64'(ph));
    chk("ovf_at_qe", 64'(a_ovf), 64'(exp_ovf));
    busy_a = int'(a_busy);
    busy_b = int'(b_busy);
    for (int k = 1; k <= FL + 1; k++) begin
      step();
      chk("sdo_a", 64'(a_sdo), 64'(stream[34-k]));
      chk("sdo_b", 64'(b_sdo), 64'(stream[34-k]));
      busy_a += int'(a_busy);
      busy_b += int'(b_busy);
    end
    chk("busy_len_a", 64'(busy_a), 64'(FL));
    chk("busy_len_b", 64'(busy_b), 64'(FL));
    chk("ovf_after_frame", 64'(a_ovf), 64'(exp_ovf));
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_sdo", 64'(a_sdo), 64'd0);
    chk("rst_po", 64'(a_po), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_ovf", 64'(a_ovf), 64'd0);
    chk("rst_din", 64'(a_din), 64'd0);
    chk("rst_load", 64'(a_load), 64'd0);
    chk("rst_pa", 64'(a_pa), 64'd0);
    rst = 1'b0;
    step();

    // deserialize and hold
    shift_word(32'hDEAD_BEEF);
    de = 1'b1; ld = 1'b1; pa = 1'b0;
    step();
    de = 1'b0; ld = 1'b0;
    chk("din_a", 64'(a_din), 64'h0000_0000_DEAD_BEEF);
    chk("din_b", 64'(b_din), 64'h0000_0000_DEAD_BEEF);
    chk("load", 64'(a_load), 64'd1);
    chk("pa", 64'(a_pa), 64'd0);
    for (int i = 0; i < 100; i++) begin
      sdi = 1'($urandom_range(0, 1));
      step();
    end
    sdi = 1'b0;
    chk("din_hold", 64'(a_din), 64'h0000_0000_DEAD_BEEF);
    chk("load_hold", 64'(a_load), 64'd1);
    chk("pa_hold", 64'(a_pa), 64'd0);

    // basic frame
    play(32'h8000_0001, 2'd2, 1'b0);

    // back-to-back: second qe exactly FL cycles after the first must not flag overrun
    core_dout = 32'hF0F0_0001;
    qe = 1'b1;
    step();
    qe = 1'b0;
    repeat (FL - 1) step();
    play(32'h0F0F_8000, 2'd3, 1'b0);

    // frame with low bits set (parity = 1 when enabled)
    play(32'h0000_0007, 2'd1, 1'b0);

    // simultaneous de and qe
    shift_word(32'h1234_5678);
    de = 1'b1; ld = 1'b0; pa = 1'b1;
    play(32'h1234_5678, 2'd0, 1'b0);
    pa = 1'b0;
    chk("din_sim_a", 64'(a_din), 64'h0000_0000_1234_5678);
    chk("din_sim_b", 64'(b_din), 64'h0000_0000_1234_5678);
    chk("load_sim", 64'(a_load), 64'd0);
    chk("pa_sim", 64'(a_pa), 64'd1);

    // overrun: qe 10 cycles into a frame
    core_dout = 32'hFFFF_0000;
    qe = 1'b1;
    step();
    qe = 1'b0;
    repeat (9) step();
    play(32'hA5A5_F00F, 2'd1, 1'b1);
    repeat (20) step();
    chk("ovf_sticky", 64'(a_ovf), 64'd1);
    chk("ovf_sticky_b", 64'(b_ovf), 64'd1);

    // reset mid-frame clears outputs before the next edge
    core_dout  = 32'hFFFF_FFFF;
    core_phase = 2'd3;
    qe = 1'b1;
    step();
    qe = 1'b0;
    repeat (15) step();
    chk("pre_rst_busy", 64'(a_busy), 64'd1);
    chk("pre_rst_sdo", 64'(a_sdo), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sdo", 64'(a_sdo), 64'd0);
    chk("mid_rst_busy", 64'(a_busy), 64'd0);
    chk("mid_rst_po", 64'(a_po), 64'd0);
    chk("mid_rst_ovf", 64'(a_ovf), 64'd0);
    chk("mid_rst_din", 64'(a_din), 64'd0);
    chk("mid_rst_din_b", 64'(b_din), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", 64'(a_busy), 64'd0);
    chk("post_rst_ovf", 64'(a_ovf), 64'd0);
    play(32'hC000_0003, 2'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
